// File: rtl/mem_readback_pkg.sv
// rtl/mem_readback_pkg.sv - shared types and constants for the memory read-back engine
package mem_readback_pkg;

    localparam int RB_DATA_W  = 32;
    localparam int RB_CNT_W   = 11;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rb_state_t;

    typedef struct packed {
        logic [RB_DATA_W-1:0] data;
        logic [RB_CNT_W-1:0]  index;
        logic                 last;
    } rb_entry_t;

endpackage

// File: rtl/readback_fifo.sv
// rtl/readback_fifo.sv - synchronous show-ahead FIFO with exported occupancy count
module readback_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_readback.sv
// rtl/mem_readback.sv - walks a word range on the external memory port and streams the words out
module mem_readback
    import mem_readback_pkg::*;
#(
    parameter int DATA_W     = RB_DATA_W,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = RB_CNT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  base_word,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              ren_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rb_state_t        state_q, state_d;
    logic [CNT_W-1:0] rd_idx_q;
    logic [CNT_W-1:0] rd_left_q, rd_left_d;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] last_idx_q;
    logic             ren_q;
    logic [ADDR_W-1:0] addr_q;

    logic             issue;
    logic             load;
    logic [CNT_W-1:0] issue_idx;
    logic             has_credit;

    rb_entry_t        push_entry;
    rb_entry_t        head;
    logic             fifo_valid;
    logic [CW-1:0]    fifo_count;

    // The read issued this cycle lands in the FIFO at the next edge, so it counts as a used slot.
    assign has_credit = (fifo_count + CW'(ren_q)) < CW'(FIFO_DEPTH);

    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        load      = 1'b0;
        issue_idx = rd_idx_q;
        rd_left_d = rd_left_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        issue     = 1'b1;
                        issue_idx = base_word;
                        rd_left_d = word_count - CNT_W'(1);
                        state_d   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_left_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (has_credit) begin
                    issue     = 1'b1;
                    rd_left_d = rd_left_q - CNT_W'(1);
                    if (rd_left_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_count == '0 && !ren_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_idx_q   <= '0;
            rd_left_q  <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            ren_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_left_q <= rd_left_d;
            ren_q     <= issue;
            if (issue) begin
                addr_q   <= ADDR_W'(issue_idx) << WORD_SHIFT;
                idx_q    <= issue_idx;
                rd_idx_q <= issue_idx + CNT_W'(1);
            end
            if (load) begin
                last_idx_q <= base_word + word_count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.data  = rdata_ext;
        push_entry.index = idx_q;
        push_entry.last  = (idx_q == last_idx_q);
    end

    readback_fifo #(
        .WIDTH ($bits(rb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ren_q),
        .wr_data (push_entry),
        .pop     (out_ready),
        .rd_data (head),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign ren_ext   = ren_q;
    assign addr_ext  = addr_q;
    // Head fields are gated so an empty FIFO presents all-zero outputs.
    assign out_valid = fifo_valid;
    assign out_data  = fifo_valid ? head.data  : '0;
    assign out_index = fifo_valid ? head.index : '0;
    assign out_last  = fifo_valid ? head.last  : 1'b0;

endmodule

// File: tb/tb_mem_readback.sv
// tb/tb_mem_readback.sv - self-checking bench for mem_readback against a word-list reference model
module tb_mem_readback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 11;
    localparam int DEPTH  = 4;
    localparam int NW     = 2048;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  base_word;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] rdata_ext;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_index;
    logic              out_last;

    logic [31:0] mem [NW];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign rdata_ext = ren_ext ? mem[addr_ext[12:2]] : 32'hBAD0_BAD0;

    mem_readback #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_word  (base_word),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .addr_ext   (addr_ext),
        .ren_ext    (ren_ext),
        .rdata_ext  (rdata_ext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if ({busy, done, ren_ext, out_valid, out_last} !== 5'b0 || addr_ext !== '0 ||
            out_data !== '0 || out_index !== '0) begin
            n_bad++;
            $display("FAIL %s: busy=%b done=%b ren=%b addr=%0h valid=%b data=%0h idx=%0d last=%b required all 0",
                     tag, busy, done, ren_ext, addr_ext, out_valid, out_data, out_index, out_last);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random ready
    task automatic run_xfer(input int base, input int cnt, input int mode, input bit poke,
                            output int done_at, output int peak);
        logic [31:0]      ed [$];
        int               ei [$];
        bit               el [$];
        int               rd_k = 0;
        int               pops = 0;
        int               dones = 0;
        int               pat = 0;
        bit               stall = 0;
        bit               rdy;
        logic [31:0]      hd = '0;
        logic [CNT_W-1:0] hi = '0;
        logic             hl = 1'b0;
        done_at = -1;
        peak = 0;
        for (int k = 0; k < cnt; k++) begin
            ed.push_back(mem[(base + k) % NW]);
            ei.push_back((base + k) % NW);
            el.push_back(k == cnt - 1);
        end
        base_word  = CNT_W'(base);
        word_count = CNT_W'(cnt);
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                base_word = CNT_W'(100);
                word_count = CNT_W'(5);
            end else begin
                start = 1'b0;
            end
            if (ren_ext) begin
                n_cmp++;
                if (rd_k >= cnt || addr_ext !== ADDR_W'(((base + rd_k) % NW) * 4)) begin
                    n_bad++;
                    $display("FAIL ren_addr read %0d of %0d: actual=%0h required=%0h",
                             rd_k, cnt, addr_ext, ((base + rd_k) % NW) * 4);
                end
                rd_k++;
                if (rd_k - pops > peak) peak = rd_k - pops;
                n_cmp++;
                if (rd_k - pops > DEPTH) begin
                    n_bad++;
                    $display("FAIL credit: outstanding actual=%0d required<=%0d", rd_k - pops, DEPTH);
                end
            end
            if (stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi || out_last !== hl) begin
                    n_bad++;
                    $display("FAIL hold: actual v=%b d=%0h i=%0d l=%b required v=1 d=%0h i=%0d l=%b",
                             out_valid, out_data, out_index, out_last, hd, hi, hl);
                end
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (pat % 4 == 0) || (pat % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pat++;
            out_ready = rdy;
            if (out_valid && rdy) begin
                n_cmp++;
                if (ed.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_word: actual idx=%0d data=%0h required none", out_index, out_data);
                end else begin
                    if (out_data !== ed[0] || out_index !== CNT_W'(ei[0]) || out_last !== el[0]) begin
                        n_bad++;
                        $display("FAIL word: actual d=%0h i=%0d l=%b required d=%0h i=%0d l=%b",
                                 out_data, out_index, out_last, ed[0], ei[0], el[0]);
                    end
                    void'(ed.pop_front());
                    void'(ei.pop_front());
                    void'(el.pop_front());
                end
                pops++;
            end
            stall = out_valid && !rdy;
            hd = out_data;
            hi = out_index;
            hl = out_last;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_at_done: actual=%b required=0", busy);
                end
            end else if (done_at < 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy: cycle %0d actual=%b required=1", cyc, busy);
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0 || ren_ext !== 1'b0) begin
                    n_bad++;
                    $display("FAIL after_done: actual valid=%b ren=%b required 0 0", out_valid, ren_ext);
                end
            end
            if (done_at >= 0 && cyc >= done_at + 3) break;
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (done_at < 0 || dones != 1) begin
            n_bad++;
            $display("FAIL done_pulses: actual=%0d required=1", dones);
        end
        n_cmp++;
        if (ed.size() != 0 || rd_k != cnt) begin
            n_bad++;
            $display("FAIL completeness: missing=%0d reads=%0d required missing=0 reads=%0d",
                     ed.size(), rd_k, cnt);
        end
    endtask

    task automatic check_done_at(input string tag, input int actual, input int required);
        n_cmp++;
        if (actual != required) begin
            n_bad++;
            $display("FAIL %s done cycle: actual=%0d required=%0d", tag, actual, required);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        base_word = '0;
        word_count = '0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");
    endtask

    task automatic test_basic();
        int d, p;
        run_xfer(0, 8, 0, 1'b0, d, p);
        check_done_at("basic", d, 11);
    endtask

    task automatic test_backpressure();
        int d, p;
        run_xfer(0, 8, 1, 1'b0, d, p);
        n_cmp++;
        if (p != DEPTH) begin
            n_bad++;
            $display("FAIL backpressure peak outstanding: actual=%0d required=%0d", p, DEPTH);
        end
    endtask

    task automatic test_zero_count();
        int d, p;
        run_xfer(300, 0, 0, 1'b0, d, p);
        check_done_at("zero", d, 1);
    endtask

    task automatic test_wrap();
        int d, p;
        run_xfer(2046, 4, 0, 1'b0, d, p);
        check_done_at("wrap", d, 7);
    endtask

    task automatic test_mid_reset();
        int d, p;
        int pops = 0;
        base_word = '0;
        word_count = CNT_W'(8);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && pops < 3; c++) begin
            if (out_valid) pops++;
            step();
        end
        n_cmp++;
        if (pops != 3) begin
            n_bad++;
            $display("FAIL mid_reset words before reset: actual=%0d required=3", pops);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("mid_reset");
        run_xfer(5, 2, 0, 1'b0, d, p);
        check_done_at("after_reset", d, 5);
    endtask

    task automatic test_ignored_start();
        int d, p;
        run_xfer(0, 8, 0, 1'b1, d, p);
        check_done_at("ignored_start", d, 11);
    endtask

    task automatic test_random();
        int d, p;
        for (int r = 0; r < 6; r++) begin
            run_xfer(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 12)), 2, 1'b0, d, p);
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) mem[i] = 32'h10 + i;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_mid_reset();
        test_ignored_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
